alu_datapath_p: RTL and testbench

//  Parametrised execute datapath for the 2-stage pipelined CPU: A/B accumulators, OUT port register,

---
 rtl/alu_datapath_p_pkg.sv | 71 +++++++
 rtl/alu_datapath_p_if.sv | 24 ++
 rtl/alu_datapath_p_gpr_file.sv | 48 ++++
 rtl/alu_datapath_p.sv | 109 ++++++++++
 tb/tb_alu_datapath_p.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/alu_datapath_p_pkg.sv
// Shared opcode map and decode helpers for the execute datapath, sequencer and decoder.
package alu_datapath_p_pkg;

    localparam int OPW = 4;

    localparam logic [3:0] OP_ADD_A  = 4'h0;
    localparam logic [3:0] OP_MOV_AB = 4'h1;
    localparam logic [3:0] OP_IN_A   = 4'h2;
    localparam logic [3:0] OP_MOV_AI = 4'h3;
    localparam logic [3:0] OP_MOV_BA = 4'h4;
    localparam logic [3:0] OP_ADD_B  = 4'h5;
    localparam logic [3:0] OP_IN_B   = 4'h6;
    localparam logic [3:0] OP_MOV_BI = 4'h7;
    localparam logic [3:0] OP_JMP_0  = 4'h8;
    localparam logic [3:0] OP_OUT_B  = 4'h9;
    localparam logic [3:0] OP_JMP_1  = 4'hA;
    localparam logic [3:0] OP_OUT_I  = 4'hB;
    localparam logic [3:0] OP_ST_B   = 4'hC;
    localparam logic [3:0] OP_LD_B   = 4'hD;
    localparam logic [3:0] OP_RSV_0  = 4'hE;
    localparam logic [3:0] OP_RSV_1  = 4'hF;

    typedef enum logic [1:0] {
        SRC_ZERO = 2'd0,
        SRC_A    = 2'd1,
        SRC_B    = 2'd2,
        SRC_IN   = 2'd3
    } src_sel_e;

    typedef enum logic [2:0] {
        DST_NONE = 3'd0,
        DST_A    = 3'd1,
        DST_B    = 3'd2,
        DST_OUT  = 3'd3,
        DST_GPR  = 3'd4,
        DST_LD   = 3'd5
    } dst_sel_e;

    typedef struct packed {
        src_sel_e src;
        dst_sel_e dst;
        logic     upd_c;
        logic     is_out;
    } decode_t;

    // Sequencer-only opcodes fall through to the default: no write, carry held.
    function automatic decode_t decode_op(input logic [3:0] op);
        decode_t d;
        d.src    = SRC_ZERO;
        d.dst    = DST_NONE;
        d.upd_c  = 1'b0;
        d.is_out = 1'b0;
        case (op)
            OP_ADD_A:  begin d.src = SRC_A;    d.dst = DST_A;   d.upd_c = 1'b1; end
            OP_MOV_AB: begin d.src = SRC_B;    d.dst = DST_A;   d.upd_c = 1'b1; end
            OP_IN_A:   begin d.src = SRC_IN;   d.dst = DST_A;   d.upd_c = 1'b1; end
            OP_MOV_AI: begin d.src = SRC_ZERO; d.dst = DST_A;   d.upd_c = 1'b1; end
            OP_MOV_BA: begin d.src = SRC_A;    d.dst = DST_B;   d.upd_c = 1'b1; end
            OP_ADD_B:  begin d.src = SRC_B;    d.dst = DST_B;   d.upd_c = 1'b1; end
            OP_IN_B:   begin d.src = SRC_IN;   d.dst = DST_B;   d.upd_c = 1'b1; end
            OP_MOV_BI: begin d.src = SRC_ZERO; d.dst = DST_B;   d.upd_c = 1'b1; end
            OP_OUT_B:  begin d.src = SRC_B;    d.dst = DST_OUT; d.upd_c = 1'b1; d.is_out = 1'b1; end
            OP_OUT_I:  begin d.src = SRC_ZERO; d.dst = DST_OUT; d.upd_c = 1'b1; d.is_out = 1'b1; end
            OP_ST_B:   begin d.dst = DST_GPR; end
            OP_LD_B:   begin d.dst = DST_LD;  end
            default:   begin d.dst = DST_NONE; end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/alu_datapath_p_if.sv
// Instruction/result bundle between the fetch/decode stage, the execute datapath and the sequencer.
interface alu_datapath_p_if #(
    parameter int WIDTH = 4,
    parameter int OPW   = 4
);
    logic                 instr_valid;
    logic [OPW+WIDTH-1:0] d_bus;
    logic [WIDTH-1:0]     in_port;
    logic                 cflag;
    logic [WIDTH-1:0]     a_reg_out;
    logic [WIDTH-1:0]     b_reg_out;
    logic [WIDTH-1:0]     out_port;
    logic                 out_valid;

    modport master (
        output instr_valid, d_bus, in_port,
        input  cflag, a_reg_out, b_reg_out, out_port, out_valid
    );

    modport slave (
        input  instr_valid, d_bus, in_port,
        output cflag, a_reg_out, b_reg_out, out_port, out_valid
    );
endinterface

// File: rtl/alu_datapath_p_gpr_file.sv
// General-purpose register array: one write port, one combinational read port.
// Out-of-range addresses drop writes and read back as zero.
module alu_datapath_p_gpr_file #(
    parameter int WIDTH     = 4,
    parameter int GPR_DEPTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             we,
    input  logic [WIDTH-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [WIDTH-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);
    localparam int             AW      = (GPR_DEPTH > 1) ? $clog2(GPR_DEPTH) : 1;
    localparam logic [WIDTH:0] DEPTH_L = (WIDTH+1)'(GPR_DEPTH);

    logic [WIDTH-1:0] mem_r [GPR_DEPTH];
    logic             wr_in_range_s;
    logic             rd_in_range_s;

    assign wr_in_range_s = ({1'b0, waddr} < DEPTH_L);
    assign rd_in_range_s = ({1'b0, raddr} < DEPTH_L);

    // Register array with asynchronous clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < GPR_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (we && wr_in_range_s) begin
            mem_r[waddr[AW-1:0]] <= wdata;
        end else begin
            mem_r <= mem_r;
        end
    end

    // Combinational read, zero when the index is beyond the array.
    always_comb begin
        rdata = '0;
        if (rd_in_range_s) begin
            rdata = mem_r[raddr[AW-1:0]];
        end else begin
            rdata = '0;
        end
    end

endmodule

// File: rtl/alu_datapath_p.sv
// Execute datapath: A/B accumulators, OUT port, carry flag and GPR file,
// driven by one decoded instruction per cycle.
module alu_datapath_p
    import alu_datapath_p_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int GPR_DEPTH = 16,
    parameter int OPW       = 4
) (
    input  logic              clock,
    input  logic              reset,
    alu_datapath_p_if.slave   bus
);
    logic [OPW-1:0]   opcode_s;
    logic [WIDTH-1:0] imm_s;
    decode_t          dec_s;
    logic [WIDTH-1:0] src_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH-1:0] gpr_rdata_s;
    logic             gpr_we_s;

    logic [WIDTH-1:0] a_r,   a_nxt_s;
    logic [WIDTH-1:0] b_r,   b_nxt_s;
    logic [WIDTH-1:0] out_r, out_nxt_s;
    logic             c_r,   c_nxt_s;
    logic             ov_r,  ov_nxt_s;

    assign opcode_s = bus.d_bus[OPW+WIDTH-1:WIDTH];
    assign imm_s    = bus.d_bus[WIDTH-1:0];
    assign dec_s    = decode_op(opcode_s);

    // Source operand select for the shared adder.
    always_comb begin
        src_s = '0;
        case (dec_s.src)
            SRC_ZERO: src_s = '0;
            SRC_A:    src_s = a_r;
            SRC_B:    src_s = b_r;
            SRC_IN:   src_s = bus.in_port;
            default:  src_s = '0;
        endcase
    end

    assign sum_s    = {1'b0, src_s} + {1'b0, imm_s};
    assign gpr_we_s = bus.instr_valid && (dec_s.dst == DST_GPR);

    alu_datapath_p_gpr_file #(
        .WIDTH     (WIDTH),
        .GPR_DEPTH (GPR_DEPTH)
    ) u_gpr (
        .clock (clock),
        .reset (reset),
        .we    (gpr_we_s),
        .waddr (imm_s),
        .wdata (b_r),
        .raddr (imm_s),
        .rdata (gpr_rdata_s)
    );

    // Next-state for architectural registers; nothing moves without instr_valid.
    always_comb begin
        a_nxt_s   = a_r;
        b_nxt_s   = b_r;
        out_nxt_s = out_r;
        c_nxt_s   = c_r;
        ov_nxt_s  = 1'b0;
        if (bus.instr_valid) begin
            case (dec_s.dst)
                DST_A:   a_nxt_s   = sum_s[WIDTH-1:0];
                DST_B:   b_nxt_s   = sum_s[WIDTH-1:0];
                DST_OUT: out_nxt_s = sum_s[WIDTH-1:0];
                DST_LD:  b_nxt_s   = gpr_rdata_s;
                default: a_nxt_s   = a_r;
            endcase
            if (dec_s.upd_c) begin
                c_nxt_s = sum_s[WIDTH];
            end else begin
                c_nxt_s = c_r;
            end
            ov_nxt_s = dec_s.is_out;
        end else begin
            ov_nxt_s = 1'b0;
        end
    end

    // Architectural state registers with asynchronous clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            a_r   <= '0;
            b_r   <= '0;
            out_r <= '0;
            c_r   <= 1'b0;
            ov_r  <= 1'b0;
        end else begin
            a_r   <= a_nxt_s;
            b_r   <= b_nxt_s;
            out_r <= out_nxt_s;
            c_r   <= c_nxt_s;
            ov_r  <= ov_nxt_s;
        end
    end

    assign bus.a_reg_out = a_r;
    assign bus.b_reg_out = b_r;
    assign bus.out_port  = out_r;
    assign bus.cflag     = c_r;
    assign bus.out_valid = ov_r;

endmodule

// File: tb/tb_alu_datapath_p.sv
// Directed bench: three datapath configurations (4/16, 4/8, 8/32) with hand-computed expectations.
module tb_alu_datapath_p;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    alu_datapath_p_if #(.WIDTH(4), .OPW(4)) bus_a ();
    alu_datapath_p_if #(.WIDTH(4), .OPW(4)) bus_b ();
    alu_datapath_p_if #(.WIDTH(8), .OPW(4)) bus_c ();

    alu_datapath_p #(.WIDTH(4), .GPR_DEPTH(16), .OPW(4)) u_a (.clock(clock), .reset(reset), .bus(bus_a));
    alu_datapath_p #(.WIDTH(4), .GPR_DEPTH(8),  .OPW(4)) u_b (.clock(clock), .reset(reset), .bus(bus_b));
    alu_datapath_p #(.WIDTH(8), .GPR_DEPTH(32), .OPW(4)) u_c (.clock(clock), .reset(reset), .bus(bus_c));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ex_a(input logic [3:0] op, input logic [3:0] imm);
        @(negedge clock);
        bus_a.instr_valid = 1'b1;
        bus_a.d_bus       = {op, imm};
        @(posedge clock);
        #1;
        bus_a.instr_valid = 1'b0;
    endtask

    task automatic ex_b(input logic [3:0] op, input logic [3:0] imm);
        @(negedge clock);
        bus_b.instr_valid = 1'b1;
        bus_b.d_bus       = {op, imm};
        @(posedge clock);
        #1;
        bus_b.instr_valid = 1'b0;
    endtask

    task automatic ex_c(input logic [3:0] op, input logic [7:0] imm);
        @(negedge clock);
        bus_c.instr_valid = 1'b1;
        bus_c.d_bus       = {op, imm};
        @(posedge clock);
        #1;
        bus_c.instr_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        @(negedge clock);
        @(posedge clock);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        bus_a.instr_valid = 1'b0; bus_a.d_bus = 8'h00;  bus_a.in_port = 4'h0;
        bus_b.instr_valid = 1'b0; bus_b.d_bus = 8'h00;  bus_b.in_port = 4'h0;
        bus_c.instr_valid = 1'b0; bus_c.d_bus = 12'h000; bus_c.in_port = 8'h00;
        reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        chk("rst_a",   {4'h0, bus_a.a_reg_out}, 8'h00);
        chk("rst_b",   {4'h0, bus_a.b_reg_out}, 8'h00);
        chk("rst_out", {4'h0, bus_a.out_port},  8'h00);
        chk("rst_c",   {7'h0, bus_a.cflag},     8'h00);
        chk("rst_ov",  {7'h0, bus_a.out_valid}, 8'h00);
        @(negedge clock);
        reset = 1'b1;

        // Accumulator arithmetic and carry
        ex_a(4'h3, 4'h5); chk("mov_a5",   {4'h0, bus_a.a_reg_out}, 8'h05); chk("mov_a5_c", {7'h0, bus_a.cflag}, 8'h00);
        ex_a(4'h0, 4'hC); chk("add_ac",   {4'h0, bus_a.a_reg_out}, 8'h01); chk("add_ac_c", {7'h0, bus_a.cflag}, 8'h01);
        ex_a(4'h3, 4'h3); chk("mov_a3",   {4'h0, bus_a.a_reg_out}, 8'h03); chk("mov_a3_c", {7'h0, bus_a.cflag}, 8'h00);

        // IN / OUT and the out_valid pulse
        bus_a.in_port = 4'h7;
        ex_a(4'h6, 4'h2); chk("in_b",     {4'h0, bus_a.b_reg_out}, 8'h09);
        ex_a(4'h9, 4'h0); chk("out_b",    {4'h0, bus_a.out_port},  8'h09); chk("out_b_ov", {7'h0, bus_a.out_valid}, 8'h01);
        idle_cycle();     chk("ov_pulse", {7'h0, bus_a.out_valid}, 8'h00); chk("out_hold", {4'h0, bus_a.out_port}, 8'h09);
        ex_a(4'hB, 4'h4); chk("out_i",    {4'h0, bus_a.out_port},  8'h04); chk("out_i_ov", {7'h0, bus_a.out_valid}, 8'h01);
        ex_a(4'h9, 4'h1); chk("out_b1",   {4'h0, bus_a.out_port},  8'h0A); chk("ov_held",  {7'h0, bus_a.out_valid}, 8'h01);
        idle_cycle();     chk("ov_drop",  {7'h0, bus_a.out_valid}, 8'h00);

        // GPR store/load with carry preserved
        ex_a(4'h7, 4'hA); chk("mov_ba",   {4'h0, bus_a.b_reg_out}, 8'h0A);
        ex_a(4'hC, 4'h3);
        ex_a(4'h7, 4'h0); chk("mov_b0",   {4'h0, bus_a.b_reg_out}, 8'h00);
        ex_a(4'h0, 4'hF); chk("add_af",   {4'h0, bus_a.a_reg_out}, 8'h02); chk("add_af_c", {7'h0, bus_a.cflag}, 8'h01);
        ex_a(4'hD, 4'h3); chk("ld_b3",    {4'h0, bus_a.b_reg_out}, 8'h0A); chk("ld_c",     {7'h0, bus_a.cflag}, 8'h01);
        ex_a(4'hC, 4'h5); chk("st_c",     {7'h0, bus_a.cflag},     8'h01); chk("st_b",     {4'h0, bus_a.b_reg_out}, 8'h0A);

        // instr_valid low and sequencer-only opcodes leave state alone
        @(negedge clock);
        bus_a.d_bus = {4'h0, 4'hF};
        @(posedge clock);
        #1;
        chk("nv_a", {4'h0, bus_a.a_reg_out}, 8'h02); chk("nv_c", {7'h0, bus_a.cflag}, 8'h01);
        ex_a(4'h8, 4'h7);
        chk("jmp_a",   {4'h0, bus_a.a_reg_out}, 8'h02); chk("jmp_b",  {4'h0, bus_a.b_reg_out}, 8'h0A);
        chk("jmp_out", {4'h0, bus_a.out_port},  8'h0A); chk("jmp_ov", {7'h0, bus_a.out_valid}, 8'h00);

        // Remaining source/destination pairings
        ex_a(4'h5, 4'h7); chk("add_b7",   {4'h0, bus_a.b_reg_out}, 8'h01); chk("add_b7_c", {7'h0, bus_a.cflag}, 8'h01);
        ex_a(4'h1, 4'h2); chk("mov_ab",   {4'h0, bus_a.a_reg_out}, 8'h03); chk("mov_ab_c", {7'h0, bus_a.cflag}, 8'h00);
        ex_a(4'h4, 4'hF); chk("mov_bx",   {4'h0, bus_a.b_reg_out}, 8'h02); chk("mov_bx_c", {7'h0, bus_a.cflag}, 8'h01);
        ex_a(4'h2, 4'h9); chk("in_a",     {4'h0, bus_a.a_reg_out}, 8'h00); chk("in_a_c",   {7'h0, bus_a.cflag}, 8'h01);

        // GPR_DEPTH=8: out-of-range index neither writes nor aliases
        ex_b(4'h7, 4'hC);
        ex_b(4'hC, 4'h7);
        ex_b(4'h7, 4'h3); chk("b_mov3",   {4'h0, bus_b.b_reg_out}, 8'h03);
        ex_b(4'hD, 4'h7); chk("b_ld7",    {4'h0, bus_b.b_reg_out}, 8'h0C);
        ex_b(4'hC, 4'hC);
        ex_b(4'hD, 4'hC); chk("b_ld_oor", {4'h0, bus_b.b_reg_out}, 8'h00);
        ex_b(4'h7, 4'h1);
        ex_b(4'hD, 4'h4); chk("b_alias",  {4'h0, bus_b.b_reg_out}, 8'h00);

        // WIDTH=8, GPR_DEPTH=32
        ex_c(4'h3, 8'h01);
        ex_c(4'h0, 8'hFF); chk("c_add",   bus_c.a_reg_out, 8'h00); chk("c_add_c", {7'h0, bus_c.cflag}, 8'h01);
        ex_c(4'h7, 8'h5A);
        ex_c(4'hC, 8'h1F);
        ex_c(4'h7, 8'h00);
        ex_c(4'hD, 8'h1F); chk("c_ld31",  bus_c.b_reg_out, 8'h5A);
        ex_c(4'hC, 8'h20);
        ex_c(4'hD, 8'h00); chk("c_alias", bus_c.b_reg_out, 8'h00);
        ex_c(4'hD, 8'h20); chk("c_ldoor", bus_c.b_reg_out, 8'h00);

        // Reset asserted mid-stream
        ex_a(4'hB, 4'h5); chk("pre_ov", {7'h0, bus_a.out_valid}, 8'h01);
        @(negedge clock);
        bus_a.instr_valid = 1'b1;
        bus_a.d_bus       = {4'h0, 4'h1};
        #2 reset = 1'b0;
        #1;
        chk("mrst_b",   {4'h0, bus_a.b_reg_out}, 8'h00);
        chk("mrst_out", {4'h0, bus_a.out_port},  8'h00);
        chk("mrst_c",   {7'h0, bus_a.cflag},     8'h00);
        chk("mrst_ov",  {7'h0, bus_a.out_valid}, 8'h00);
        @(posedge clock);
        #1;
        chk("mrst_a", {4'h0, bus_a.a_reg_out}, 8'h00);
        @(negedge clock);
        bus_a.instr_valid = 1'b0;
        reset = 1'b1;
        ex_a(4'h7, 4'h1);
        ex_a(4'hD, 4'h3); chk("mrst_gpr", {4'h0, bus_a.b_reg_out}, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
